// File: rtl/alarm_ctrl_pkg.sv
// Shared types for the alarm setting controller.
// Holds the session state enum, display field codes and decode helpers.
package alarm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETONOFF,
    ST_SETHOUR,
    ST_SETMIN
  } alm_state_t;

  localparam logic [1:0] EF_NONE  = 2'd0;
  localparam logic [1:0] EF_ONOFF = 2'd1;
  localparam logic [1:0] EF_HOUR  = 2'd2;
  localparam logic [1:0] EF_MIN   = 2'd3;

  function automatic alm_state_t next_mode(
    input alm_state_t s
  );
    alm_state_t r;
    unique case (s)
      ST_IDLE:     r = ST_SELECT;
      ST_SELECT:   r = ST_SETONOFF;
      ST_SETONOFF: r = ST_SETHOUR;
      ST_SETHOUR:  r = ST_SETMIN;
      default:     r = ST_IDLE;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] field_of(
    input alm_state_t s
  );
    logic [1:0] r;
    unique case (s)
      ST_SETONOFF: r = EF_ONOFF;
      ST_SETHOUR:  r = EF_HOUR;
      ST_SETMIN:   r = EF_MIN;
      default:     r = EF_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multi_alarm_ctrl_key_repeat.sv
// Edge detector with hold-then-repeat pulse generator for one key.
// Ports: clock, reset, key level, enable (repeat allowed), rise, rep.
module key_repeat #(
  parameter int HOLD_CYCLES   = 500,
  parameter int REPEAT_CYCLES = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  input  logic enable,
  output logic rise,
  output logic rep
);

  localparam int MAXC =
    (HOLD_CYCLES > REPEAT_CYCLES) ?
    HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = $clog2(MAXC + 1);

  logic          prev;
  logic          armed;
  logic          phase;
  logic [RW-1:0] cnt;
  logic [RW-1:0] limit;

  // prev resets to 1 so a key held through reset gives no rise
  assign rise  = key & ~prev;
  assign limit = phase ? RW'(REPEAT_CYCLES)
                       : RW'(HOLD_CYCLES);
  assign rep   = armed & key & enable &
                 (cnt == limit);

  always_ff @(posedge clock) begin
    if (reset) begin
      prev  <= 1'b1;
      armed <= 1'b0;
      phase <= 1'b0;
      cnt   <= '0;
    end else begin
      prev <= key;
      if (rise && enable) begin
        armed <= 1'b1;
        phase <= 1'b0;
        cnt   <= RW'(1);
      end else if (!key || !enable) begin
        armed <= 1'b0;
        phase <= 1'b0;
        cnt   <= '0;
      end else if (armed) begin
        if (rep) begin
          phase <= 1'b1;
          cnt   <= RW'(1);
        end else if (cnt != RW'(MAXC)) begin
          cnt <= cnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Two-key alarm edit controller: mode key walks the edit fields,
// adjust key edits the selected alarm. Outputs are registered pulses.
module multi_alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int NUM_ALARMS     = 4,
  parameter int HOLD_CYCLES    = 500,
  parameter int REPEAT_CYCLES  = 100,
  parameter int TIMEOUT_CYCLES = 10000,
  localparam int IDXW =
    (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sw_f1,
  input  logic            sw_f2,
  output logic [IDXW-1:0] alm_sel,
  output logic            alm_onoff,
  output logic            alm_hour,
  output logic            alm_min,
  output logic [1:0]      edit_field,
  output logic            active
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  alm_state_t    state;
  alm_state_t    nxt;
  logic          f1_prev;
  logic          f1_rise;
  logic          f2_rise;
  logic          f2_rep;
  logic          f2_go;
  logic          rep_en;
  logic          to_hit;
  logic [TW-1:0] tcnt;

  assign f1_rise = sw_f1 & ~f1_prev;

  key_repeat #(
    .HOLD_CYCLES  (HOLD_CYCLES),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) u_f2 (
    .clock (clock),
    .reset (reset),
    .key   (sw_f2),
    .enable(rep_en),
    .rise  (f2_rise),
    .rep   (f2_rep)
  );

  // a mode change on this edge kills both the F2 action and the repeat
  always_comb begin
    rep_en = ((state == ST_SETHOUR) ||
              (state == ST_SETMIN)) && !f1_rise;
    f2_go  = !f1_rise;
    to_hit = (state != ST_IDLE) && !f1_rise &&
             !f2_rise && !f2_rep &&
             (tcnt == TW'(TIMEOUT_CYCLES - 1));
    nxt = state;
    if (f1_rise) nxt = next_mode(state);
    else if (to_hit) nxt = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      f1_prev    <= 1'b1;
      state      <= ST_IDLE;
      alm_sel    <= '0;
      alm_onoff  <= 1'b0;
      alm_hour   <= 1'b0;
      alm_min    <= 1'b0;
      edit_field <= EF_NONE;
      active     <= 1'b0;
      tcnt       <= '0;
    end else begin
      f1_prev    <= sw_f1;
      state      <= nxt;
      edit_field <= field_of(nxt);
      active     <= (nxt != ST_IDLE);
      alm_onoff  <= f2_go && f2_rise &&
                    (state == ST_SETONOFF);
      alm_hour   <= f2_go && (f2_rise || f2_rep) &&
                    (state == ST_SETHOUR);
      alm_min    <= f2_go && (f2_rise || f2_rep) &&
                    (state == ST_SETMIN);
      if (f2_go && f2_rise &&
          (state == ST_SELECT)) begin
        if (alm_sel >= IDXW'(NUM_ALARMS - 1))
          alm_sel <= '0;
        else
          alm_sel <= alm_sel + IDXW'(1);
      end
      if ((nxt == ST_IDLE) || f1_rise ||
          f2_rise || f2_rep)
        tcnt <= '0;
      else if (tcnt != TW'(TIMEOUT_CYCLES))
        tcnt <= tcnt + TW'(1);
    end
  end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Scoreboard bench for multi_alarm_ctrl.
// Expected pulses are queued at stimulus time and matched per cycle.
module tb_multi_alarm_ctrl;

  localparam int NA = 4;
  localparam int HC = 8;
  localparam int RC = 4;
  localparam int TC = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       sw_f1 = 1'b0;
  logic       sw_f2 = 1'b0;
  logic [1:0] alm_sel;
  logic       alm_onoff;
  logic       alm_hour;
  logic       alm_min;
  logic [1:0] edit_field;
  logic       active;

  multi_alarm_ctrl #(
    .NUM_ALARMS    (NA),
    .HOLD_CYCLES   (HC),
    .REPEAT_CYCLES (RC),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .sw_f1     (sw_f1),
    .sw_f2     (sw_f2),
    .alm_sel   (alm_sel),
    .alm_onoff (alm_onoff),
    .alm_hour  (alm_hour),
    .alm_min   (alm_min),
    .edit_field(edit_field),
    .active    (active)
  );

  always #5 clock = ~clock;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } exp_t;

  localparam logic [2:0] K_ONOFF = 3'b100;
  localparam logic [2:0] K_HOUR  = 3'b010;
  localparam logic [2:0] K_MIN   = 3'b001;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [1:0] exp_sel = '0;

  always @(posedge clock) cyc++;

  always @(negedge clock) begin : mon
    logic [2:0] obs;
    logic [2:0] ex;
    obs = {alm_onoff, alm_hour, alm_min};
    ex = 3'b000;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      ex = q[0].kind;
      void'(q.pop_front());
    end
    if (obs != 3'b000 || ex != 3'b000) begin
      n_chk++;
      if (obs !== ex) begin
        n_fail++;
        $display("FAIL pulse cyc=%0d got=%b want=%b",
                 cyc, obs, ex);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clock);
  endtask

  task automatic press_f1();
    sw_f1 = 1'b1;
    tick();
    sw_f1 = 1'b0;
    tick();
  endtask

  task automatic tap_f2(input logic [2:0] kind);
    sw_f2 = 1'b1;
    if (kind != 3'b000)
      q.push_back('{cyc: cyc + 1, kind: kind});
    tick();
    sw_f2 = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sw_f1 = 1'b1;
    sw_f2 = 1'b1;
    tick(4);
    n_chk++;
    if ({active, edit_field, alm_sel} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=0",
               {active, edit_field, alm_sel});
    end
    reset = 1'b0;
    tick(3);
    n_chk++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL held_key_no_rise active=%b want=0",
               active);
    end
    sw_f1 = 1'b0;
    sw_f2 = 1'b0;
    tick(2);
    press_f1();
    n_chk++;
    if (active !== 1'b1 || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL enter_select act=%b ef=%0d want 1/0",
               active, edit_field);
    end
  endtask

  task automatic test_select();
    for (int i = 0; i < 5; i++) begin
      tap_f2(3'b000);
      exp_sel = exp_sel + 2'd1;
      n_chk++;
      if (alm_sel !== exp_sel) begin
        n_fail++;
        $display("FAIL sel_step%0d got=%0d want=%0d",
                 i, alm_sel, exp_sel);
      end
    end
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ef;
      press_f1();
      ef = (i == 3) ? 2'd0 : 2'(i + 1);
      n_chk++;
      if (edit_field !== ef ||
          active !== (i != 3)) begin
        n_fail++;
        $display("FAIL mode_walk%0d ef=%0d act=%b want ef=%0d",
                 i, edit_field, active, ef);
      end
    end
    n_chk++;
    if (alm_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL sel_retained got=%0d want=1", alm_sel);
    end
  endtask

  task automatic test_onoff();
    press_f1();
    press_f1();
    for (int i = 0; i < 3; i++) tap_f2(K_ONOFF);
    tick(2);
    press_f1();
    press_f1();
    press_f1();
    n_chk++;
    if (active !== 1'b0) begin
      n_fail++;
      $display("FAIL onoff_exit active=%b want=0", active);
    end
  endtask

  task automatic test_repeat();
    press_f1();
    press_f1();
    press_f1();
    n_chk++;
    if (edit_field !== 2'd2) begin
      n_fail++;
      $display("FAIL in_hour ef=%0d want=2", edit_field);
    end
    sw_f2 = 1'b1;
    q.push_back('{cyc: cyc + 1,  kind: K_HOUR});
    q.push_back('{cyc: cyc + 9,  kind: K_HOUR});
    q.push_back('{cyc: cyc + 13, kind: K_HOUR});
    q.push_back('{cyc: cyc + 17, kind: K_HOUR});
    tick(20);
    sw_f2 = 1'b0;
    tick(4);
    press_f1();
    press_f1();
  endtask

  task automatic test_timeout();
    int t0;
    press_f1();
    press_f1();
    press_f1();
    sw_f1 = 1'b1;
    tick();
    sw_f1 = 1'b0;
    t0 = cyc;
    tick(15);
    n_chk++;
    if (active !== 1'b1 || edit_field !== 2'd3) begin
      n_fail++;
      $display("FAIL pre_timeout cyc+%0d act=%b ef=%0d",
               cyc - t0, active, edit_field);
    end
    tick();
    n_chk++;
    if (active !== 1'b0 || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout cyc+%0d act=%b want=0",
               cyc - t0, active);
    end
    for (int i = 0; i < 4; i++) press_f1();
    sw_f2 = 1'b1;
    q.push_back('{cyc: cyc + 1, kind: K_MIN});
    for (int off = 9; off <= 36; off += RC)
      q.push_back('{cyc: cyc + off, kind: K_MIN});
    tick(36);
    n_chk++;
    if (active !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_no_timeout act=%b want=1",
               active);
    end
    sw_f2 = 1'b0;
    tick();
    press_f1();
  endtask

  task automatic test_simul();
    for (int i = 0; i < 4; i++) press_f1();
    sw_f1 = 1'b1;
    sw_f2 = 1'b1;
    tick();
    n_chk++;
    if (active !== 1'b0 || edit_field !== 2'd0) begin
      n_fail++;
      $display("FAIL f1_wins act=%b ef=%0d want 0/0",
               active, edit_field);
    end
    sw_f1 = 1'b0;
    sw_f2 = 1'b0;
    tick(2);
  endtask

  task automatic test_reset_mid();
    press_f1();
    press_f1();
    press_f1();
    sw_f2 = 1'b1;
    q.push_back('{cyc: cyc + 1, kind: K_HOUR});
    q.push_back('{cyc: cyc + 9, kind: K_HOUR});
    tick(12);
    reset = 1'b1;
    tick();
    n_chk++;
    if ({alm_onoff, alm_hour, alm_min, active,
         edit_field, alm_sel} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_mid got=%b want=0",
               {alm_onoff, alm_hour, alm_min, active,
                edit_field, alm_sel});
    end
    reset = 1'b0;
    sw_f2 = 1'b0;
    tick(3);
  endtask

  initial begin
    test_reset();
    test_select();
    test_onoff();
    test_repeat();
    test_timeout();
    test_simul();
    test_reset_mid();
    tick(2);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_pulses left=%0d want=0",
               q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
